// File: rtl/nr_mem_bank.sv
// nr_mem_bank: synchronous memory bank with one write port and N_RD read
// ports, a hardware clear sweep started by clr, a selectable read-during-write
// policy, per-port read-valid flags and a one-cycle access-error pulse.
module nr_mem_bank #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int N_RD     = 2,
  parameter bit WR_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_valid,
  output logic                     busy,
  output logic                     acc_err
);

  // Index width of the storage array; addresses are range-checked before use.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  logic [1:0]              state_r;
  logic [ADDR_W-1:0]       ptr_r;
  logic                    busy_r;
  logic                    acc_err_r;
  logic [N_RD*DATA_W-1:0]  rd_data_r;
  logic [N_RD-1:0]         rd_valid_r;
  logic [DATA_W-1:0]       mem_r [DEPTH];

  logic                    sweep_s;
  logic                    wr_ok_s;
  logic                    mem_we_s;
  logic [IDX_W-1:0]        mem_idx_s;
  logic [DATA_W-1:0]       mem_wd_s;
  logic [N_RD*DATA_W-1:0]  rd_data_nx_s;
  logic [N_RD-1:0]         rd_valid_nx_s;
  logic                    acc_idle_s;

  // True when an address maps onto a physical word.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (32'(addr) < DEPTH);
  endfunction

  // RST counts as the first sweep step (pointer is already 0 there).
  assign sweep_s = (state_r == ST_RST) || (state_r == ST_SWEEP);
  assign wr_ok_s = (state_r == ST_IDLE) && wr_en && in_range(wr_addr);

  // Select the single memory write: sweep zeroing or an accepted user write.
  always_comb begin
    mem_we_s  = 1'b0;
    mem_idx_s = IDX_W'(ptr_r);
    mem_wd_s  = {DATA_W{1'b0}};
    if (clr) begin
      mem_we_s = 1'b0;
    end else if (sweep_s) begin
      mem_we_s  = 1'b1;
      mem_idx_s = IDX_W'(ptr_r);
      mem_wd_s  = {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      mem_we_s  = 1'b1;
      mem_idx_s = IDX_W'(wr_addr);
      mem_wd_s  = wr_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Next read results and error flag for an IDLE cycle, per port.
  always_comb begin
    rd_data_nx_s  = rd_data_r;
    rd_valid_nx_s = {N_RD{1'b0}};
    acc_idle_s    = wr_en && !in_range(wr_addr);
    for (int k = 0; k < N_RD; k++) begin
      logic [ADDR_W-1:0] ra;
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (rd_en[k]) begin
        if (in_range(ra)) begin
          rd_valid_nx_s[k] = 1'b1;
          if (WR_FIRST && wr_ok_s && (wr_addr == ra)) begin
            rd_data_nx_s[k*DATA_W +: DATA_W] = wr_data;
          end else begin
            rd_data_nx_s[k*DATA_W +: DATA_W] = mem_r[IDX_W'(ra)];
          end
        end else begin
          rd_data_nx_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
          acc_idle_s = 1'b1;
        end
      end else begin
        rd_data_nx_s[k*DATA_W +: DATA_W] = rd_data_r[k*DATA_W +: DATA_W];
      end
    end
  end

  // Storage array; no reset, contents are defined by the clear sweep only.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wd_s;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= ST_RST;
      ptr_r      <= {ADDR_W{1'b0}};
      busy_r     <= 1'b1;
      acc_err_r  <= 1'b0;
      rd_data_r  <= {(N_RD*DATA_W){1'b0}};
      rd_valid_r <= {N_RD{1'b0}};
    end else begin
      case (state_r)
        ST_RST, ST_SWEEP: begin
          acc_err_r  <= wr_en | (|rd_en);
          rd_valid_r <= {N_RD{1'b0}};
          if (32'(ptr_r) == DEPTH - 1) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            ptr_r   <= {ADDR_W{1'b0}};
          end else begin
            state_r <= ST_SWEEP;
            busy_r  <= 1'b1;
            ptr_r   <= ptr_r + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          busy_r     <= 1'b0;
          rd_data_r  <= rd_data_nx_s;
          rd_valid_r <= rd_valid_nx_s;
          acc_err_r  <= acc_idle_s;
        end
        default: begin
          state_r    <= ST_RST;
          ptr_r      <= {ADDR_W{1'b0}};
          busy_r     <= 1'b1;
          acc_err_r  <= 1'b0;
          rd_valid_r <= {N_RD{1'b0}};
        end
      endcase
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign acc_err  = acc_err_r;

endmodule

// File: doc/nr_mem_bank.md
# nr_mem_bank

Parametrised synchronous memory bank for the nanoRisk processor, serving as both the data memory and the instruction memory. It has one write port and N_RD independent read ports, all on a single clock edge. It adds a hardware clear sweep, a configurable read-during-write policy, per-port read-valid flags and access-error reporting. It sits between the datapath/fetch unit and the register/ALU stages.

## Interface
- DATA_W, 8: word width in bits
- ADDR_W, 8: address width in bits
- DEPTH, 256: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W
- N_RD, 2: number of read ports (1..4)
- WR_FIRST, 1: 1 = same-cycle read of the address being written returns new data; 0 = returns old data
---
- clk  in  1  clock; every state change happens on the rising edge
- clr  in  1  synchronous, active-high reset; also starts the clear sweep
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  N_RD  per-port read request
- rd_addr  in  N_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data, packed the same way as rd_addr
- rd_valid  out  N_RD  per-port flag: rd_data is valid this cycle
- busy  out  1  clear sweep in progress
- acc_err  out  1  one-cycle pulse on a rejected access

## Operation
- **States:** RST, SWEEP, IDLE.
- **RST** (any cycle with clr=1):
  - sweep pointer ← 0
  - rd_data ← 0, rd_valid ← 0, acc_err ← 0, busy ← 1
  - next state is RST while clr=1, else SWEEP
- **SWEEP:**
  - each cycle writes 0 to mem[ptr] and then increments ptr
  - after writing ptr = DEPTH-1, goes to IDLE; busy deasserts on that same edge
  - the sweep lasts exactly DEPTH cycles
  - clr=1 mid-sweep restarts from RST; ptr returns to 0
- **IDLE, write:** when wr_en=1 and wr_addr < DEPTH, mem[wr_addr] ← wr_data.
- **IDLE, read:** for each port k with rd_en[k]=1 and rd_addr[k] < DEPTH:
  - rd_data[k] ← mem[rd_addr[k]], rd_valid[k] ← 1
  - if wr_en=1 and wr_addr == rd_addr[k] in the same cycle, rd_data[k] ← wr_data when WR_FIRST=1, else the old contents
- **Ports without rd_en:** when rd_en[k]=0, rd_data[k] holds its previous value and rd_valid[k] ← 0.
- **Out-of-range address** (≥ DEPTH), checked per port:
  - a write is dropped
  - a read gives rd_data[k] ← 0, rd_valid[k] ← 0
  - acc_err ← 1 for one cycle
- **Access during busy:** any wr_en=1 or rd_en≠0 while busy=1 (RST or SWEEP) is ignored, and acc_err pulses for one cycle. The exception is a cycle with clr=1, where acc_err is forced to 0.
- **Multiple reads:** several ports may read the same address in one cycle; each receives identical data.
- **Memory state:** memory contents are not defined before the first completed sweep. The only initialisation is the sweep, triggered by clr.

## Timing
- Read latency is 1 cycle: address and rd_en are sampled at edge n, and rd_data/rd_valid are valid after edge n.
- Write-to-read latency:
  - 0 cycles at the same address when WR_FIRST=1
  - 1 cycle when WR_FIRST=0 (the read must be issued on the following edge)
- After clr is released at edge r, busy=1 through edge r+DEPTH and reads 0 after edge r+DEPTH. The first access is accepted at edge r+DEPTH+1.
- acc_err is registered and asserts after the offending edge, for exactly one cycle per offending cycle.
- Reset values: rd_data=0, rd_valid=0, acc_err=0, busy=1.

## Test plan
- **Reset and sweep:** DEPTH=16, pulse clr for 1 cycle → busy=1 for 16 cycles, then 0. Afterwards, reading all 16 addresses returns 0x00, with rd_valid=1 one cycle after each request.
- **Basic write/read:** write 0xA5 @0x03, then read port 0 @0x03 on the next cycle → rd_data[0]=0xA5 and rd_valid[0]=1 after one cycle. Port 1 reading @0x04 in the same cycle → 0x00.
- **Read-during-write:** mem[0x07]=0x11, then in one cycle write 0x22 @0x07 while both ports read @0x07.
  - WR_FIRST=1 → both ports give 0x22
  - WR_FIRST=0 → both ports give 0x11, and the next read gives 0x22
- **Access during busy:** issue wr_en @0x05=0x33 on the 3rd sweep cycle → acc_err pulses once. After the sweep, mem[0x05] reads 0x00.
- **Out-of-range:** DEPTH=12, ADDR_W=4; write 0x44 @0x0E → acc_err=1 and the write is dropped. Read @0x0E → rd_data=0, rd_valid=0, acc_err=1. Reads of addresses 0x00–0x0B are unaffected.
- **Reset mid-sweep:** assert clr on the 8th sweep cycle of a 16-word sweep → busy stays 1, and a full 16-cycle sweep restarts after clr is released. A write issued just before clr does not survive.
